// File: rtl/gcd_arb_pkg.sv
// Shared types and default sizing for the GCD client arbiter.
// Default-config widths are exported here; the top re-derives them from its own parameters.
package gcd_arb_pkg;
  localparam int GCD_ARB_M_DEF = 4;
  localparam int GCD_ARB_D_DEF = 8;
  localparam int GCD_ARB_W_DEF = 32;
  localparam int ID_W  = $clog2(GCD_ARB_M_DEF);
  localparam int CNT_W = $clog2(GCD_ARB_D_DEF + 1);
  typedef logic [ID_W-1:0] client_id_t;
endpackage

// File: rtl/fifo.sv
// Synchronous FIFO with occupancy count; no bypass between push and pop.
// Callers must not push when full or pop when empty.
module fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wp, r_rp;
  logic [CW-1:0]    r_cnt;
  logic             w_push, w_pop;

  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;
  assign full   = (r_cnt == CW'(DEPTH));
  assign empty  = (r_cnt == '0);
  assign count  = r_cnt;
  assign dout   = r_mem[r_rp];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      if (w_push & ~w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (~w_push & w_pop) r_cnt <= r_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= din;
  end
endmodule

// File: rtl/gcd_client_arbiter_gcd_rr_pick.sv
// Combinational round-robin picker: first valid index at or after ptr, wrapping mod M.
module gcd_rr_pick #(
  parameter int M    = 4,
  parameter int ID_W = 2
) (
  input  logic [M-1:0]    valid,
  input  logic [ID_W-1:0] ptr,
  output logic            any,
  output logic [ID_W-1:0] grant
);
  logic [ID_W-1:0] w_idx;

  // Walk from the farthest offset back to ptr so the nearest valid wins.
  always_comb begin
    any   = 1'b0;
    grant = '0;
    w_idx = '0;
    for (int k = M-1; k >= 0; k--) begin
      w_idx = ID_W'((int'(ptr) + k) % M);
      if (valid[w_idx]) begin
        any   = 1'b1;
        grant = w_idx;
      end
    end
  end
endmodule

// File: rtl/gcd_client_arbiter.sv
// Round-robin M-client front end for a shared GCD stream; a tag FIFO routes in-order results back.
// Define GCD_ARB_STATS_EN to add the saturating stall_cycles counter output.
module gcd_client_arbiter
  import gcd_arb_pkg::*;
#(
  parameter int W = GCD_ARB_W_DEF,
  parameter int M = GCD_ARB_M_DEF,
  parameter int D = GCD_ARB_D_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [M-1:0]             client_req_val,
  input  logic [M*W-1:0]           client_req_bits_A,
  input  logic [M*W-1:0]           client_req_bits_B,
  output logic [M-1:0]             client_req_rdy,
  output logic                     gcd_req_val,
  output logic [W-1:0]             gcd_req_bits_A,
  output logic [W-1:0]             gcd_req_bits_B,
  input  logic                     gcd_req_rdy,
  input  logic                     gcd_resp_val,
  input  logic [W-1:0]             gcd_resp_bits_data,
  output logic                     gcd_resp_rdy,
  output logic [M-1:0]             client_resp_val,
  output logic [W-1:0]             client_resp_bits_data,
  input  logic [M-1:0]             client_resp_rdy,
  output logic [$clog2(D+1)-1:0]   outstanding,
`ifdef GCD_ARB_STATS_EN
  output logic [31:0]              stall_cycles,
`endif
  output logic                     err_orphan
);
  localparam int LID_W  = $clog2(M);
  localparam int LCNT_W = $clog2(D+1);

  logic [LID_W-1:0]  r_ptr;
  logic [LID_W-1:0]  w_grant, w_head;
  logic              w_any, w_full, w_empty;
  logic              w_req_fire, w_resp_fire;
  logic [LCNT_W-1:0] w_count;
  logic              r_err_orphan;

  gcd_rr_pick #(.M(M), .ID_W(LID_W)) u_pick (
    .valid (client_req_val),
    .ptr   (r_ptr),
    .any   (w_any),
    .grant (w_grant)
  );

  fifo #(.WIDTH(LID_W), .DEPTH(D)) u_tag_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_req_fire),
    .din   (w_grant),
    .pop   (w_resp_fire),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  assign gcd_req_val    = w_any & ~w_full & ~reset;
  assign gcd_req_bits_A = w_any ? client_req_bits_A[int'(w_grant)*W +: W] : '0;
  assign gcd_req_bits_B = w_any ? client_req_bits_B[int'(w_grant)*W +: W] : '0;
  assign w_req_fire     = gcd_req_val & gcd_req_rdy;

  assign gcd_resp_rdy          = ~w_empty & client_resp_rdy[w_head] & ~reset;
  assign w_resp_fire           = gcd_resp_val & gcd_resp_rdy;
  assign client_resp_bits_data = gcd_resp_bits_data;
  assign outstanding           = w_count;
  assign err_orphan            = r_err_orphan;

  always_comb begin
    client_req_rdy = '0;
    if (w_req_fire) client_req_rdy[w_grant] = 1'b1;
  end

  always_comb begin
    client_resp_val = '0;
    if (gcd_resp_val & ~w_empty & ~reset) client_resp_val[w_head] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr        <= '0;
      r_err_orphan <= 1'b0;
    end else begin
      if (w_req_fire)
        r_ptr <= (w_grant == LID_W'(M-1)) ? '0 : w_grant + 1'b1;
      if (gcd_resp_val & w_empty) r_err_orphan <= 1'b1;
    end
  end

`ifdef GCD_ARB_STATS_EN
  logic [31:0] r_stall_cycles;
  assign stall_cycles = r_stall_cycles;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_stall_cycles <= '0;
    else if ((|client_req_val) & ~w_req_fire & ~(&r_stall_cycles))
      r_stall_cycles <= r_stall_cycles + 1'b1;
  end
`endif
endmodule

// File: tb/tb_gcd_client_arbiter.sv
// Directed bench for gcd_client_arbiter at M=4, W=16, D=4.
module tb_gcd_client_arbiter;
  localparam int W = 16;
  localparam int M = 4;
  localparam int D = 4;

  logic           clk, reset;
  logic [M-1:0]   client_req_val;
  logic [M*W-1:0] client_req_bits_A, client_req_bits_B;
  logic [M-1:0]   client_req_rdy;
  logic           gcd_req_val;
  logic [W-1:0]   gcd_req_bits_A, gcd_req_bits_B;
  logic           gcd_req_rdy;
  logic           gcd_resp_val;
  logic [W-1:0]   gcd_resp_bits_data;
  logic           gcd_resp_rdy;
  logic [M-1:0]   client_resp_val;
  logic [W-1:0]   client_resp_bits_data;
  logic [M-1:0]   client_resp_rdy;
  logic [2:0]     outstanding;
  logic           err_orphan;

  int errors = 0;
  int checks = 0;

  gcd_client_arbiter #(.W(W), .M(M), .D(D)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .client_req_val        (client_req_val),
    .client_req_bits_A     (client_req_bits_A),
    .client_req_bits_B     (client_req_bits_B),
    .client_req_rdy        (client_req_rdy),
    .gcd_req_val           (gcd_req_val),
    .gcd_req_bits_A        (gcd_req_bits_A),
    .gcd_req_bits_B        (gcd_req_bits_B),
    .gcd_req_rdy           (gcd_req_rdy),
    .gcd_resp_val          (gcd_resp_val),
    .gcd_resp_bits_data    (gcd_resp_bits_data),
    .gcd_resp_rdy          (gcd_resp_rdy),
    .client_resp_val       (client_resp_val),
    .client_resp_bits_data (client_resp_bits_data),
    .client_resp_rdy       (client_resp_rdy),
    .outstanding           (outstanding),
    .err_orphan            (err_orphan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    client_req_val     = '0;
    client_req_bits_A  = '0;
    client_req_bits_B  = '0;
    gcd_req_rdy        = 1'b0;
    gcd_resp_val       = 1'b0;
    gcd_resp_bits_data = '0;
    client_resp_rdy    = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    #2 reset = 1'b1;
    #7 reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    client_req_val     = 4'b1111;
    gcd_req_rdy        = 1'b1;
    gcd_resp_val       = 1'b1;
    client_resp_rdy    = 4'b1111;
    #13;
    checks++; if (gcd_req_val !== 1'b0) begin errors++; $display("FAIL rst_req_val got %b exp 0", gcd_req_val); end
    checks++; if (client_req_rdy !== 4'b0000) begin errors++; $display("FAIL rst_req_rdy got %b exp 0000", client_req_rdy); end
    checks++; if (gcd_resp_rdy !== 1'b0) begin errors++; $display("FAIL rst_resp_rdy got %b exp 0", gcd_resp_rdy); end
    checks++; if (client_resp_val !== 4'b0000) begin errors++; $display("FAIL rst_resp_val got %b exp 0000", client_resp_val); end
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL rst_outstanding got %0d exp 0", outstanding); end
    idle_inputs();
    reset = 1'b0;
    tick();
    checks++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL rst_orphan got %b exp 0", err_orphan); end
  endtask

  // Four back-to-back grants fill the FIFO, then one pop frees a slot.
  task automatic test_rr_fill_and_full();
    do_reset();
    for (int i = 0; i < M; i++) begin
      client_req_bits_A[i*W +: W] = W'(16'h10 + i);
      client_req_bits_B[i*W +: W] = W'(16'h20 + i);
    end
    client_req_val = 4'b1111;
    gcd_req_rdy    = 1'b1;
    #1;
    for (int k = 0; k < M; k++) begin
      checks++; if (client_req_rdy !== 4'(1 << k)) begin errors++; $display("FAIL rr_grant%0d got %b exp %b", k, client_req_rdy, 4'(1 << k)); end
      checks++; if (gcd_req_bits_A !== W'(16'h10 + k)) begin errors++; $display("FAIL rr_bitsA%0d got %0h exp %0h", k, gcd_req_bits_A, 16'h10 + k); end
      tick();
    end
    checks++; if (gcd_req_val !== 1'b0) begin errors++; $display("FAIL full_req_val got %b exp 0", gcd_req_val); end
    checks++; if (outstanding !== 3'd4) begin errors++; $display("FAIL full_outstanding got %0d exp 4", outstanding); end

    gcd_resp_val       = 1'b1;
    gcd_resp_bits_data = 16'd7;
    client_resp_rdy    = 4'b1111;
    #1;
    checks++; if (client_resp_val !== 4'b0001) begin errors++; $display("FAIL pop_resp_val got %b exp 0001", client_resp_val); end
    checks++; if (gcd_resp_rdy !== 1'b1) begin errors++; $display("FAIL pop_resp_rdy got %b exp 1", gcd_resp_rdy); end
    checks++; if (gcd_req_val !== 1'b0) begin errors++; $display("FAIL pop_no_issue got %b exp 0", gcd_req_val); end
    checks++; if (client_req_rdy !== 4'b0000) begin errors++; $display("FAIL pop_no_rdy got %b exp 0000", client_req_rdy); end
    tick();
    gcd_resp_val = 1'b0;
    #1;
    checks++; if (outstanding !== 3'd3) begin errors++; $display("FAIL after_pop_outstanding got %0d exp 3", outstanding); end
    checks++; if (client_req_rdy !== 4'b0001) begin errors++; $display("FAIL resume_grant got %b exp 0001", client_req_rdy); end
    tick();
    checks++; if (outstanding !== 3'd4) begin errors++; $display("FAIL resume_outstanding got %0d exp 4", outstanding); end
  endtask

  task automatic test_single_client();
    do_reset();
    client_req_val = 4'b0100;
    client_req_bits_A[2*W +: W] = 16'd48;
    client_req_bits_B[2*W +: W] = 16'd18;
    gcd_req_rdy = 1'b0;
    #1;
    checks++; if (gcd_req_val !== 1'b1) begin errors++; $display("FAIL val_indep_rdy got %b exp 1", gcd_req_val); end
    checks++; if (client_req_rdy !== 4'b0000) begin errors++; $display("FAIL no_fire_rdy got %b exp 0000", client_req_rdy); end
    gcd_req_rdy = 1'b1;
    #1;
    checks++; if (client_req_rdy !== 4'b0100) begin errors++; $display("FAIL c2_req_rdy got %b exp 0100", client_req_rdy); end
    checks++; if (gcd_req_bits_A !== 16'd48) begin errors++; $display("FAIL c2_bitsA got %0d exp 48", gcd_req_bits_A); end
    checks++; if (gcd_req_bits_B !== 16'd18) begin errors++; $display("FAIL c2_bitsB got %0d exp 18", gcd_req_bits_B); end
    tick();
    client_req_val = '0;
    #1;
    checks++; if (outstanding !== 3'd1) begin errors++; $display("FAIL c2_outstanding got %0d exp 1", outstanding); end
    checks++; if (gcd_req_bits_A !== 16'd0) begin errors++; $display("FAIL idle_bitsA got %0d exp 0", gcd_req_bits_A); end
    gcd_resp_val       = 1'b1;
    gcd_resp_bits_data = 16'd6;
    client_resp_rdy    = 4'b1111;
    #1;
    checks++; if (client_resp_val !== 4'b0100) begin errors++; $display("FAIL c2_resp_val got %b exp 0100", client_resp_val); end
    checks++; if (client_resp_bits_data !== 16'd6) begin errors++; $display("FAIL c2_resp_data got %0d exp 6", client_resp_bits_data); end
    checks++; if (gcd_resp_rdy !== 1'b1) begin errors++; $display("FAIL c2_resp_rdy got %b exp 1", gcd_resp_rdy); end
    tick();
    gcd_resp_val = 1'b0;
    #1;
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL c2_drained got %0d exp 0", outstanding); end
    checks++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL c2_orphan got %b exp 0", err_orphan); end
  endtask

  task automatic test_resp_backpressure();
    do_reset();
    client_req_val = 4'b0010;
    gcd_req_rdy    = 1'b1;
    tick();
    client_req_val     = '0;
    gcd_resp_val       = 1'b1;
    gcd_resp_bits_data = 16'd9;
    client_resp_rdy    = 4'b1101;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++; if (gcd_resp_rdy !== 1'b0) begin errors++; $display("FAIL bp_resp_rdy%0d got %b exp 0", k, gcd_resp_rdy); end
      checks++; if (client_resp_val !== 4'b0010) begin errors++; $display("FAIL bp_resp_val%0d got %b exp 0010", k, client_resp_val); end
      tick();
    end
    checks++; if (outstanding !== 3'd1) begin errors++; $display("FAIL bp_outstanding got %0d exp 1", outstanding); end
    client_resp_rdy = 4'b1111;
    #1;
    checks++; if (gcd_resp_rdy !== 1'b1) begin errors++; $display("FAIL bp_release got %b exp 1", gcd_resp_rdy); end
    tick();
    gcd_resp_val = 1'b0;
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL bp_drained got %0d exp 0", outstanding); end
  endtask

  task automatic test_orphan();
    do_reset();
    gcd_resp_val    = 1'b1;
    client_resp_rdy = 4'b1111;
    #1;
    checks++; if (gcd_resp_rdy !== 1'b0) begin errors++; $display("FAIL orph_resp_rdy got %b exp 0", gcd_resp_rdy); end
    checks++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL orph_early got %b exp 0", err_orphan); end
    tick();
    checks++; if (err_orphan !== 1'b1) begin errors++; $display("FAIL orph_set got %b exp 1", err_orphan); end
    gcd_resp_val = 1'b0;
    tick();
    tick();
    checks++; if (err_orphan !== 1'b1) begin errors++; $display("FAIL orph_sticky got %b exp 1", err_orphan); end
  endtask

  task automatic test_reset_midop();
    do_reset();
    client_req_val = 4'b1111;
    gcd_req_rdy    = 1'b1;
    tick(); tick(); tick();
    checks++; if (outstanding !== 3'd3) begin errors++; $display("FAIL mid_outstanding got %0d exp 3", outstanding); end
    checks++; if (client_req_rdy !== 4'b1000) begin errors++; $display("FAIL mid_grant got %b exp 1000", client_req_rdy); end
    #3 reset = 1'b1;
    #1;
    checks++; if (gcd_req_val !== 1'b0) begin errors++; $display("FAIL mid_rst_val got %b exp 0", gcd_req_val); end
    checks++; if (client_req_rdy !== 4'b0000) begin errors++; $display("FAIL mid_rst_rdy got %b exp 0000", client_req_rdy); end
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL mid_rst_outstanding got %0d exp 0", outstanding); end
    #2 reset = 1'b0;
    #1;
    checks++; if (client_req_rdy !== 4'b0001) begin errors++; $display("FAIL mid_first_grant got %b exp 0001", client_req_rdy); end
    checks++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL mid_orphan_clr got %b exp 0", err_orphan); end
    tick();
    checks++; if (outstanding !== 3'd1) begin errors++; $display("FAIL mid_after got %0d exp 1", outstanding); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_rr_fill_and_full();
    test_single_client();
    test_resp_backpressure();
    test_orphan();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/gcd_client_arbiter.md
Name: gcd_client_arbiter

Overview:
- Shares one GCD operand/result stream among M independent clients, each with its own val/rdy request and response channels.
- Round-robin arbitration on the request side.
- An internal tag FIFO records which client issued each request, so in-order results route back to the issuing client.
- Sits upstream of the multi-unit GCD array: the array's input/output FIFO ports connect to this block's gcd_* side.

Parameters:
- W, 32, operand/result width in bits
- M, 4, number of clients (>=2)
- D, 8, tag FIFO depth = max outstanding requests (power of 2)

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- client_req_val  input  M  per-client request valid
- client_req_bits_A  input  M*W  client i operand A at bits [i*W +: W]
- client_req_bits_B  input  M*W  client i operand B, same packing
- client_req_rdy  output  M  per-client request accepted
- gcd_req_val  output  1  request valid toward GCD array
- gcd_req_bits_A  output  W  granted client's operand A
- gcd_req_bits_B  output  W  granted client's operand B
- gcd_req_rdy  input  1  GCD array accepts request
- gcd_resp_val  input  1  result valid from GCD array
- gcd_resp_bits_data  input  W  result data
- gcd_resp_rdy  output  1  result accepted
- client_resp_val  output  M  per-client result valid
- client_resp_bits_data  output  W  result data, broadcast to all clients
- client_resp_rdy  input  M  per-client result ready
- outstanding  output  $clog2(D+1)  requests issued but not yet returned
- err_orphan  output  1  sticky: response arrived with no outstanding tag

Behaviour:
- Reset (async, active-high):
  - Clears rr pointer to 0, tag FIFO to empty, outstanding to 0 and err_orphan to 0.
  - All val/rdy outputs are 0 while reset is asserted.
- Grant selection:
  - grant = first i with client_req_val[i], searching from ptr upward and wrapping mod M.
  - Combinational; no added latency.
- gcd_req_val = |client_req_val & !tag_full. It must not depend on gcd_req_rdy.
- gcd_req_bits_A/B show the granted client's operands, and are 0 when no client is valid.
- Request fire = gcd_req_val & gcd_req_rdy.
  - client_req_rdy[grant] = fire; all other bits are 0.
  - On fire: push grant into tag FIFO, ptr <= (grant+1) mod M.
  - Without a fire, ptr holds. There is no fairness credit for idle clients.
- Response routing:
  - head = tag FIFO head, empty = tag FIFO empty.
  - client_resp_val[i] = gcd_resp_val & !empty & (head==i).
  - gcd_resp_rdy = !empty & client_resp_rdy[head].
  - Response fire = gcd_resp_val & gcd_resp_rdy; it pops the tag FIFO.
- Full FIFO:
  - No request issue, even if a pop occurs the same cycle. There is no bypass of pop-frees-slot.
- Empty FIFO:
  - No response accepted, even if a push occurs the same cycle. There is no enqueue-to-dequeue bypass; the tag becomes visible the next cycle.
- Simultaneous push and pop when neither full nor empty: both occur, and outstanding is unchanged.
- outstanding = registered count: +1 on push, -1 on pop, net 0 on both. It equals FIFO occupancy.
- err_orphan sets when gcd_resp_val & empty & !reset. It is cleared only by reset.
- Reset mid-operation discards all tags. The GCD array must be reset together with this block.

Optional Feature:
- GCD_ARB_STATS_EN defined adds output stall_cycles [31:0]: counts cycles with |client_req_val & !fire, saturating at 2^32-1, cleared by reset.
- Undefined: no port and no counter logic.

Decomposition:
- Package gcd_arb_pkg holds:
  - localparams ID_W = $clog2(M) and CNT_W = $clog2(D+1).
  - A client_id_t typedef of width ID_W.
- One sub-module, gcd_rr_pick: combinational round-robin picker with inputs valid[M] and ptr, and outputs any and grant id.
- The tag FIFO reuses the existing fifo module with width ID_W and depth D.

Test Plan:
All scenarios use M=4, W=16, D=4.
- All four clients valid, gcd_req_rdy=1, responses held off: grants 0,1,2,3 in consecutive cycles, then gcd_req_val=0 (full), outstanding=4.
- Only client 2 valid with A=48, B=18; array returns 6: client_req_rdy=4'b0100, then client_resp_val=4'b0100 with data 6, outstanding returns to 0.
- FIFO full (outstanding=4), one response popped: no issue in the pop cycle; issue in the next cycle resumes from ptr.
- Head tag=1 with client_resp_rdy[1]=0 and others 1: gcd_resp_rdy=0, the response holds, and client_resp_val stays 4'b0010 until rdy[1]=1.
- gcd_resp_val=1 with FIFO empty: gcd_resp_rdy=0, err_orphan=1 from next cycle and persists after gcd_resp_val drops.
- Reset asserted mid-cycle with outstanding=3: outputs clear immediately (asynchronously); after release, outstanding=0, ptr=0, and the first grant goes to client 0 when all clients are valid.
